// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the machine-mode trap sequencer: CSR addresses, causes,
// mstatus bit positions, FSM encoding and the CSR write payload.
package trap_ctrl_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CSR_AW = 12;

  localparam logic [CSR_AW-1:0] CSR_MSTATUS = 12'h300;
  localparam logic [CSR_AW-1:0] CSR_MIE     = 12'h304;
  localparam logic [CSR_AW-1:0] CSR_MTVEC   = 12'h305;
  localparam logic [CSR_AW-1:0] CSR_MEPC    = 12'h341;
  localparam logic [CSR_AW-1:0] CSR_MCAUSE  = 12'h342;

  localparam logic [XLEN-1:0] CAUSE_ECALL_M = 32'd11;
  localparam logic [XLEN-1:0] CAUSE_MEI     = 32'h8000_000B;

  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;
  localparam int unsigned MIE_MEIE       = 11;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_SAVE_EPC    = 3'd1,
    ST_SAVE_CAUSE  = 3'd2,
    ST_SAVE_STATUS = 3'd3,
    ST_RESTORE     = 3'd4,
    ST_REDIRECT    = 3'd5
  } trap_state_e;

  typedef struct packed {
    logic              we;
    logic [CSR_AW-1:0] addr;
    logic [XLEN-1:0]   data;
  } csr_wr_t;

  // mstatus as written on trap entry: stack MIE into MPIE, disable, MPP=M
  function automatic logic [XLEN-1:0] mstatus_on_trap(input logic [XLEN-1:0] s);
    logic [XLEN-1:0] m;
    m = s;
    m[MSTATUS_MPIE] = s[MSTATUS_MIE];
    m[MSTATUS_MIE]  = 1'b0;
    m[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return m;
  endfunction

  // mstatus as written by MRET: pop MPIE into MIE, set MPIE
  function automatic logic [XLEN-1:0] mstatus_on_mret(input logic [XLEN-1:0] s);
    logic [XLEN-1:0] m;
    m = s;
    m[MSTATUS_MIE]  = s[MSTATUS_MPIE];
    m[MSTATUS_MPIE] = 1'b1;
    m[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return m;
  endfunction

endpackage

// File: rtl/trap_vec_calc.sv
// Redirect target: saved mepc for MRET, otherwise mtvec base, offset by
// 4*code for interrupts in vectored mode.
module trap_vec_calc
  import trap_ctrl_pkg::*;
(
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] cause,
  input  logic            is_mret,
  input  logic [XLEN-1:0] mepc,
  output logic [XLEN-1:0] target_c
);

  logic [XLEN-1:0] base_c;
  logic [XLEN-1:0] offset_c;
  logic            vectored_c;
  logic            unused_cause_c;

  assign base_c         = {mtvec[XLEN-1:2], 2'b00};
  assign offset_c       = {cause[XLEN-3:0], 2'b00};
  assign unused_cause_c = cause[XLEN-2];

  // Reserved modes 2'b10/2'b11 fall back to direct
  assign vectored_c = (mtvec[1:0] == 2'b01) && cause[XLEN-1];

  always_comb begin
    target_c = base_c;
    if (is_mret) begin
      target_c = mepc;
    end else if (vectored_c) begin
      target_c = base_c + offset_c;
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: accepts ECALL/MRET/external interrupt at commit,
// issues one CSR write per cycle, then redirects the PC.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cm_valid,
  input  logic              cm_exception,
  input  logic [XLEN-1:0]   cm_cause,
  input  logic              cm_is_mret,
  input  logic [XLEN-1:0]   cm_pc,
  input  logic              irq_ext,
  input  logic [XLEN-1:0]   csr_mstatus,
  input  logic [XLEN-1:0]   csr_mie,
  input  logic [XLEN-1:0]   csr_mtvec,
  input  logic [XLEN-1:0]   csr_mepc,
  output logic              trap_take,
  output logic              flush,
  output logic              stall,
  output logic              csr_we,
  output logic [CSR_AW-1:0] csr_waddr,
  output logic [XLEN-1:0]   csr_wdata,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc,
  output logic              busy
);

  trap_state_e     state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] mstatus_q, mstatus_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic            is_mret_q, is_mret_d;
  csr_wr_t         csr_wr_q, csr_wr_d;
  logic            redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic            stall_q, stall_d;
  logic            flush_q, flush_d;
  logic            busy_q, busy_d;

  logic            irq_pend_c;
  logic            accept_c;
  logic [XLEN-1:0] target_c;
  logic            unused_mie_c;

  assign irq_pend_c   = irq_ext & csr_mstatus[MSTATUS_MIE] & csr_mie[MIE_MEIE];
  assign unused_mie_c = ^{csr_mie[XLEN-1:MIE_MEIE+1], csr_mie[MIE_MEIE-1:0]};

  // Gated by rstn so nothing is accepted while reset is held
  assign accept_c = rstn && (state_q == ST_IDLE) && cm_valid &&
                    (irq_pend_c || cm_exception || cm_is_mret);

  trap_vec_calc u_vec (
    .mtvec    (mtvec_d),
    .cause    (cause_d),
    .is_mret  (is_mret_d),
    .mepc     (mepc_d),
    .target_c (target_c)
  );

  // Next state, latches, and next-cycle output values
  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    cause_d          = cause_q;
    mstatus_d        = mstatus_q;
    mtvec_d          = mtvec_q;
    mepc_d           = mepc_q;
    is_mret_d        = is_mret_q;
    csr_wr_d         = '0;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = RESET_PC;

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          pc_d      = cm_pc;
          mstatus_d = csr_mstatus;
          mtvec_d   = csr_mtvec;
          mepc_d    = csr_mepc;
          is_mret_d = 1'b0;
          state_d   = ST_SAVE_EPC;
          if (irq_pend_c) begin
            cause_d = CAUSE_MEI;
          end else if (cm_exception) begin
            cause_d = cm_cause;
          end else begin
            cause_d   = '0;
            is_mret_d = 1'b1;
            state_d   = ST_RESTORE;
          end
        end
      end
      ST_SAVE_EPC:    state_d = ST_SAVE_CAUSE;
      ST_SAVE_CAUSE:  state_d = ST_SAVE_STATUS;
      ST_SAVE_STATUS: state_d = ST_REDIRECT;
      ST_RESTORE:     state_d = ST_REDIRECT;
      ST_REDIRECT:    state_d = ST_IDLE;
      default:        state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_SAVE_EPC:    csr_wr_d = '{we: 1'b1, addr: CSR_MEPC, data: {pc_d[XLEN-1:2], 2'b00}};
      ST_SAVE_CAUSE:  csr_wr_d = '{we: 1'b1, addr: CSR_MCAUSE, data: cause_d};
      ST_SAVE_STATUS: csr_wr_d = '{we: 1'b1, addr: CSR_MSTATUS, data: mstatus_on_trap(mstatus_d)};
      ST_RESTORE:     csr_wr_d = '{we: 1'b1, addr: CSR_MSTATUS, data: mstatus_on_mret(mstatus_d)};
      ST_REDIRECT: begin
        redirect_valid_d = 1'b1;
        redirect_pc_d    = target_c;
      end
      default: ;
    endcase

    busy_d  = (state_d != ST_IDLE);
    stall_d = busy_d && (state_d != ST_REDIRECT);
    flush_d = (state_d == ST_REDIRECT);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q          <= ST_IDLE;
      pc_q             <= '0;
      cause_q          <= '0;
      mstatus_q        <= '0;
      mtvec_q          <= '0;
      mepc_q           <= '0;
      is_mret_q        <= 1'b0;
      csr_wr_q         <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= RESET_PC;
      stall_q          <= 1'b0;
      flush_q          <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      cause_q          <= cause_d;
      mstatus_q        <= mstatus_d;
      mtvec_q          <= mtvec_d;
      mepc_q           <= mepc_d;
      is_mret_q        <= is_mret_d;
      csr_wr_q         <= csr_wr_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      stall_q          <= stall_d;
      flush_q          <= flush_d;
      busy_q           <= busy_d;
    end
  end

  assign trap_take      = accept_c;
  assign flush          = accept_c | flush_q;
  assign stall          = stall_q;
  assign csr_we         = csr_wr_q.we;
  assign csr_waddr      = csr_wr_q.addr;
  assign csr_wdata      = csr_wr_q.data;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: ECALL, MRET, interrupt, priority, reset abort
// and cm_valid gating, with hand-computed expected CSR writes and targets.
module tb_trap_ctrl;

  localparam logic [31:0] RPC = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cm_valid, cm_exception, cm_is_mret, irq_ext;
  logic [31:0] cm_cause, cm_pc, csr_mstatus, csr_mie, csr_mtvec, csr_mepc;
  logic        trap_take, flush, stall, csr_we, redirect_valid, busy;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata, redirect_pc;

  int n_tests = 0;
  int n_fail  = 0;

  trap_ctrl #(.RESET_PC(RPC)) dut (
    .clk(clk), .rstn(rstn),
    .cm_valid(cm_valid), .cm_exception(cm_exception), .cm_cause(cm_cause),
    .cm_is_mret(cm_is_mret), .cm_pc(cm_pc), .irq_ext(irq_ext),
    .csr_mstatus(csr_mstatus), .csr_mie(csr_mie), .csr_mtvec(csr_mtvec),
    .csr_mepc(csr_mepc),
    .trap_take(trap_take), .flush(flush), .stall(stall), .csr_we(csr_we),
    .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cm();
    cm_valid = 1'b0; cm_exception = 1'b0; cm_is_mret = 1'b0; irq_ext = 1'b0;
  endtask

  task automatic exp_out(input string tag, input logic tt, input logic we,
                         input logic [11:0] a, input logic [31:0] d, input logic rv,
                         input logic [31:0] rpc, input logic st, input logic fl,
                         input logic bz);
    chk({tag, ".trap_take"}, 32'(trap_take), 32'(tt));
    chk({tag, ".csr_we"}, 32'(csr_we), 32'(we));
    chk({tag, ".csr_waddr"}, 32'(csr_waddr), 32'(a));
    chk({tag, ".csr_wdata"}, csr_wdata, d);
    chk({tag, ".redirect_valid"}, 32'(redirect_valid), 32'(rv));
    chk({tag, ".redirect_pc"}, redirect_pc, rpc);
    chk({tag, ".stall"}, 32'(stall), 32'(st));
    chk({tag, ".flush"}, 32'(flush), 32'(fl));
    chk({tag, ".busy"}, 32'(busy), 32'(bz));
  endtask

  // Checks T+1..T+5 of a trap; caller has set up and checked cycle T
  task automatic seq_trap(input string tag, input logic hold, input logic [31:0] epc,
                          input logic [31:0] cause, input logic [31:0] st_w,
                          input logic [31:0] tgt);
    step(); if (!hold) clear_cm();
    exp_out({tag, ".t1"}, 0, 1, 12'h341, epc, 0, RPC, 1, 0, 1);
    step();
    exp_out({tag, ".t2"}, 0, 1, 12'h342, cause, 0, RPC, 1, 0, 1);
    step();
    exp_out({tag, ".t3"}, 0, 1, 12'h300, st_w, 0, RPC, 1, 0, 1);
    clear_cm();
    step();
    exp_out({tag, ".t4"}, 0, 0, 12'h000, 32'h0, 1, tgt, 0, 1, 1);
    step();
    exp_out({tag, ".t5"}, 0, 0, 12'h000, 32'h0, 0, RPC, 0, 0, 0);
  endtask

  initial begin
    rstn = 1'b0;
    clear_cm();
    cm_cause = '0; cm_pc = '0; csr_mstatus = '0; csr_mie = '0;
    csr_mtvec = '0; csr_mepc = '0;
    #12;
    exp_out("reset", 0, 0, 12'h000, 32'h0, 0, RPC, 0, 0, 0);
    step(); rstn = 1'b1;
    step();
    exp_out("idle", 0, 0, 12'h000, 32'h0, 0, RPC, 0, 0, 0);

    // ECALL at 0x100, direct mtvec 0x200
    cm_valid = 1; cm_exception = 1; cm_cause = 32'd11; cm_pc = 32'h100;
    csr_mtvec = 32'h200; csr_mstatus = 32'h8; csr_mie = 32'h800;
    #1;
    exp_out("ecall.t0", 1, 0, 12'h000, 32'h0, 0, RPC, 0, 1, 0);
    seq_trap("ecall", 0, 32'h100, 32'd11, 32'h1880, 32'h200);

    // MRET: restore mstatus, return to mepc
    cm_valid = 1; cm_is_mret = 1; cm_pc = 32'h300;
    csr_mstatus = 32'h1880; csr_mepc = 32'h104;
    #1;
    exp_out("mret.t0", 1, 0, 12'h000, 32'h0, 0, RPC, 0, 1, 0);
    step(); clear_cm();
    exp_out("mret.t1", 0, 1, 12'h300, 32'h1888, 0, RPC, 1, 0, 1);
    step();
    exp_out("mret.t2", 0, 0, 12'h000, 32'h0, 1, 32'h104, 0, 1, 1);
    step();
    exp_out("mret.t3", 0, 0, 12'h000, 32'h0, 0, RPC, 0, 0, 0);

    // Vectored interrupt, inputs held through busy and must be ignored
    csr_mstatus = 32'h8; csr_mtvec = 32'h301; csr_mie = 32'h800;
    cm_valid = 1; irq_ext = 1; cm_pc = 32'h40;
    #1;
    exp_out("irq.t0", 1, 0, 12'h000, 32'h0, 0, RPC, 0, 1, 0);
    seq_trap("irq", 1, 32'h40, 32'h8000_000B, 32'h1880, 32'h32C);

    // Interrupt beats ECALL; mepc low bits cleared; direct mode
    csr_mstatus = 32'h8; csr_mtvec = 32'h200;
    cm_valid = 1; irq_ext = 1; cm_exception = 1; cm_cause = 32'd11; cm_pc = 32'h82;
    #1;
    chk("prio.t0.trap_take", 32'(trap_take), 32'h1);
    seq_trap("prio_irq", 0, 32'h80, 32'h8000_000B, 32'h1880, 32'h200);

    // Same with MIE=0: ECALL taken; vectored mtvec ignored for exceptions
    csr_mstatus = 32'h0; csr_mtvec = 32'h201;
    cm_valid = 1; irq_ext = 1; cm_exception = 1; cm_cause = 32'd11; cm_pc = 32'h82;
    #1;
    chk("prio_mie0.t0.trap_take", 32'(trap_take), 32'h1);
    seq_trap("prio_ecall", 0, 32'h80, 32'd11, 32'h1800, 32'h200);

    // Reset during T+2 aborts the sequence
    csr_mstatus = 32'h8; csr_mtvec = 32'h200;
    cm_valid = 1; cm_exception = 1; cm_cause = 32'd11; cm_pc = 32'h100;
    #1;
    chk("abort.t0.trap_take", 32'(trap_take), 32'h1);
    step(); clear_cm();
    chk("abort.t1.csr_waddr", 32'(csr_waddr), 32'h341);
    step();
    chk("abort.t2.csr_waddr", 32'(csr_waddr), 32'h342);
    #2; rstn = 1'b0; #1;
    exp_out("abort.rst", 0, 0, 12'h000, 32'h0, 0, RPC, 0, 0, 0);
    step(); rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      exp_out($sformatf("abort.after%0d", i), 0, 0, 12'h000, 32'h0, 0, RPC, 0, 0, 0);
    end

    // Pending interrupt without cm_valid: no accept until cm_valid rises
    csr_mstatus = 32'h8; csr_mie = 32'h800; csr_mtvec = 32'h302;
    irq_ext = 1; cm_valid = 0; cm_pc = 32'h204;
    for (int i = 0; i < 3; i++) begin
      #1;
      exp_out($sformatf("novalid%0d", i), 0, 0, 12'h000, 32'h0, 0, RPC, 0, 0, 0);
      step();
    end
    cm_valid = 1;
    #1;
    chk("valid.t0.trap_take", 32'(trap_take), 32'h1);
    seq_trap("valid", 0, 32'h204, 32'h8000_000B, 32'h1880, 32'h300);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
